// File: rtl/counter_pkg.sv
// Shared types and elaboration helpers for the modulo counter family.
package counter_pkg;

  typedef enum logic [0:0] {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } count_mode_e;

  // Legal range is 2 <= modulus <= 2**width; width bounded so the limit fits a longint.
  function automatic bit legal_modulus(input int width, input int modulus);
    longint lim;
    if ((width < 32'sd1) || (width > 32'sd62)) begin
      return 1'b0;
    end else begin
      lim = 64'sd1 <<< width;
      return (longint'(modulus) >= 64'sd2) && (longint'(modulus) <= lim);
    end
  endfunction

endpackage

// File: rtl/modulo_step.sv
// Combinational next-count computation for modulo_counter: load clamping and
// boundary handling, evaluated in WIDTH+1 bits so MODULUS == 2**WIDTH is exact.
module modulo_step
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 10,
  parameter int          MODULUS = 1000,
  parameter count_mode_e MODE    = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             clamp_evt
);

  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_EXT = {(WIDTH+1){1'b0}};

  logic [WIDTH:0] count_ext_s;
  logic [WIDTH:0] load_ext_s;

  assign count_ext_s = {1'b0, count};
  assign load_ext_s  = {1'b0, load_val};

  // Select load value, step, wrap or clamp; event flags are raw and unqualified by en.
  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    clamp_evt  = 1'b0;
    if (load) begin
      if (load_ext_s > MAX_EXT) begin
        next_count = MAX_VAL;
        clamp_evt  = 1'b1;
      end else begin
        next_count = load_val;
      end
    end else if (up) begin
      if (count_ext_s >= MAX_EXT) begin
        wrap_evt   = 1'b1;
        next_count = (MODE == CNT_SAT) ? MAX_VAL : {WIDTH{1'b0}};
      end else begin
        next_count = WIDTH'(count_ext_s + ONE_EXT);
      end
    end else begin
      if (count_ext_s == ZERO_EXT) begin
        wrap_evt   = 1'b1;
        next_count = (MODE == CNT_SAT) ? {WIDTH{1'b0}} : MAX_VAL;
      end else begin
        next_count = WIDTH'(count_ext_s - ONE_EXT);
      end
    end
  end

endmodule

// File: rtl/modulo_counter.sv
// Up/down modulo counter with wrap or saturate behaviour, load clamping and
// registered status flags; all state lives here, next-value math in modulo_step.
module modulo_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 10,
  parameter int          MODULUS = 1000,
  parameter count_mode_e MODE    = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if (!legal_modulus(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("modulo_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  logic [WIDTH-1:0] count_r, step_next_s, next_count_s;
  logic             tc_r, wrap_r, ovf_r, load_err_r;
  logic             next_tc_s, next_wrap_s, next_ovf_s, next_load_err_s;
  logic             wrap_evt_s, clamp_evt_s;

  modulo_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .MODE    (MODE)
  ) u_step (
    .count      (count_r),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .next_count (step_next_s),
    .wrap_evt   (wrap_evt_s),
    .clamp_evt  (clamp_evt_s)
  );

  // Priority clr > load > en > hold; pulses default low, ovf accumulates until clr.
  always_comb begin
    next_count_s    = count_r;
    next_wrap_s     = 1'b0;
    next_load_err_s = 1'b0;
    next_ovf_s      = ovf_r;
    if (clr) begin
      next_count_s = {WIDTH{1'b0}};
      next_ovf_s   = 1'b0;
    end else if (load) begin
      next_count_s    = step_next_s;
      next_load_err_s = clamp_evt_s;
      next_ovf_s      = ovf_r | clamp_evt_s;
    end else if (en) begin
      next_count_s = step_next_s;
      next_wrap_s  = wrap_evt_s;
      next_ovf_s   = ovf_r | wrap_evt_s;
    end else begin
      next_count_s = count_r;
    end
    next_tc_s = up ? (next_count_s == MAX_VAL) : (next_count_s == {WIDTH{1'b0}});
  end

  // State and flag registers; async reset discards any in-flight event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= {WIDTH{1'b0}};
      tc_r       <= 1'b0;
      wrap_r     <= 1'b0;
      ovf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= next_count_s;
      tc_r       <= next_tc_s;
      wrap_r     <= next_wrap_s;
      ovf_r      <= next_ovf_s;
      load_err_r <= next_load_err_s;
    end
  end

  assign count    = count_r;
  assign tc       = tc_r;
  assign wrap     = wrap_r;
  assign ovf      = ovf_r;
  assign load_err = load_err_r;

endmodule

// File: doc/modulo_counter.md
MODULO_COUNTER -- requirements
Module: modulo_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning count width in bits.
REQ-002 SHALL have parameter MODULUS, default 1000, meaning the count range 0..MODULUS-1; legal values are 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter MODE, type count_mode_e, default CNT_WRAP, meaning wrap vs saturate at the range limits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-011 SHALL have port count, output, WIDTH bits: current count, driven directly from a register.
REQ-012 SHALL have port tc, output, 1 bit: terminal count, registered. It is 1 when count is MODULUS-1 and up=1, or when count is 0 and up=0.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle registered pulse marking a boundary crossing.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag marking a boundary crossing or clamp.
REQ-015 SHALL have port load_err, output, 1 bit: one-cycle registered pulse marking an out-of-range load.

Function
REQ-016 Per-cycle priority SHALL be: clr, then load, then en, then hold.
REQ-017 On clr: count SHALL go to 0; ovf, wrap and load_err SHALL go to 0.
REQ-018 On load with load_val < MODULUS: count SHALL take load_val on the next edge.
REQ-019 On load with load_val >= MODULUS: count SHALL take MODULUS-1, load_err SHALL pulse, and ovf SHALL set.
REQ-020 On en with up=1 and count < MODULUS-1: count SHALL increment by 1.
REQ-021 On en with up=0 and count > 0: count SHALL decrement by 1.
REQ-022 On en, up=1, count == MODULUS-1: in CNT_WRAP, count SHALL go to 0; in CNT_SAT, count SHALL hold. In both modes, wrap SHALL pulse and ovf SHALL set.
REQ-023 On en, up=0, count == 0: in CNT_WRAP, count SHALL go to MODULUS-1; in CNT_SAT, count SHALL hold. In both modes, wrap SHALL pulse and ovf SHALL set.
REQ-024 Latency SHALL be one cycle from any input to count, wrap and load_err; no combinational input-to-output paths are permitted.
REQ-025 tc SHALL be recomputed every cycle from the next count and the current up, so it is valid in the same cycle count shows the boundary value.
REQ-026 wrap and load_err SHALL be 0 in every cycle in which their event did not occur on the preceding edge.
REQ-027 ovf SHALL stay set until clr or reset.
REQ-028 count SHALL never leave 0..MODULUS-1 under any input sequence.
REQ-029 All next-value arithmetic SHALL use WIDTH+1 bits so that MODULUS == 2**WIDTH produces no silent truncation.
REQ-030 Direction changes SHALL take effect on the same edge with no dead cycle.
REQ-031 When en=0 with no clr or load, all state SHALL hold, and wrap and load_err SHALL read 0.

Reset
REQ-032 When rst_n=0, asynchronously: count SHALL be 0, tc SHALL be 0, wrap SHALL be 0, ovf SHALL be 0, load_err SHALL be 0.
REQ-033 Deassertion of rst_n SHALL be assumed synchronised externally; the first count change SHALL occur on the first rising edge with rst_n=1 and en=1.
REQ-034 Reset asserted mid-count SHALL discard any in-flight load or wrap event, and no pulse SHALL appear after release.

Structure
REQ-035 Package counter_pkg SHALL hold the typedef enum count_mode_e {CNT_WRAP, CNT_SAT}.
REQ-036 Package counter_pkg SHALL hold the constant function for the legal-modulus check, used in an elaboration-time assertion.
REQ-037 One combinational sub-module, modulo_step, SHALL compute next_count, wrap_evt and clamp_evt from count, up, load, load_val and MODE.
REQ-038 All registers SHALL live in modulo_counter.

Verification
REQ-039 Defaults, en=1, up=1, 1000 cycles from reset: count SHALL go 0..999 then 0; wrap SHALL pulse once, in the cycle count=0; tc SHALL be 1 while count=999; ovf SHALL be 1 afterwards.
REQ-040 MODE=CNT_SAT, load_val=997, then en/up=1 for 5 cycles: count SHALL read 998, 999, 999, 999, 999; wrap SHALL pulse on each hold attempt.
REQ-041 Defaults, count=0, up=0, en=1: count SHALL go to 999 with a wrap pulse; the next cycle count SHALL be 998.
REQ-042 load=1 with load_val=1023 (MODULUS=1000): count SHALL be 999 and load_err SHALL pulse. clr, load and en asserted together: count SHALL be 0 and all flags 0.
REQ-043 WIDTH=4, MODULUS=16, up for 17 cycles: count SHALL wrap 15 -> 0 with no X values or truncation.
REQ-044 rst_n asserted low mid-cycle at count=500: count SHALL be 0 immediately, before the next clock edge; all flags SHALL be 0; counting SHALL resume from 0 after release.
